// File: rtl/decode_queue.sv
// RV32I (+ optional RV32M) decode stage: a DEPTH-entry FIFO of fetched {inst, pc}
// whose head is decoded into a registered, valid/ready handshaked output bundle.
module decode_queue #(
  parameter int DEPTH    = 4,
  parameter bit ENABLE_M = 1'b0,
  parameter int PC_W     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst,
  input  logic [PC_W-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [4:0]               out_alu_op,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [4:0]               out_rd,
  output logic [31:0]              out_imm,
  output logic                     out_use_imm,
  output logic                     out_write_reg,
  output logic [3:0]               out_mem_wea,
  output logic [2:0]               out_mem_len,
  output logic                     out_mem_signed,
  output logic                     out_is_load,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   out_count
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [4:0] {
    OP_NOP  = 5'd0,  OP_ADD  = 5'd1,  OP_SUB    = 5'd2,  OP_SLL   = 5'd3,
    OP_SLT  = 5'd4,  OP_SLTU = 5'd5,  OP_XOR    = 5'd6,  OP_SRL   = 5'd7,
    OP_SRA  = 5'd8,  OP_OR   = 5'd9,  OP_AND    = 5'd10, OP_LUI   = 5'd11,
    OP_AUIPC= 5'd12, OP_JAL  = 5'd13, OP_JALR   = 5'd14, OP_BEQ   = 5'd15,
    OP_BNE  = 5'd16, OP_BLT  = 5'd17, OP_BGE    = 5'd18, OP_BLTU  = 5'd19,
    OP_BGEU = 5'd20, OP_MUL  = 5'd21, OP_MULH   = 5'd22, OP_MULHSU= 5'd23,
    OP_MULHU= 5'd24, OP_DIV  = 5'd25, OP_DIVU   = 5'd26, OP_REM   = 5'd27,
    OP_REMU = 5'd28
  } alu_op_e;

  typedef struct packed {
    alu_op_e     alu_op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
    logic        write_reg;
    logic [3:0]  mem_wea;
    logic [2:0]  mem_len;
    logic        mem_signed;
    logic        is_load;
    logic        illegal;
  } dec_t;

  function automatic alu_op_e base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return OP_ADD;
      3'b001:  return OP_SLL;
      3'b010:  return OP_SLT;
      3'b011:  return OP_SLTU;
      3'b100:  return OP_XOR;
      3'b101:  return OP_SRL;
      3'b110:  return OP_OR;
      default: return OP_AND;
    endcase
  endfunction

  function automatic alu_op_e m_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return OP_MUL;
      3'b001:  return OP_MULH;
      3'b010:  return OP_MULHSU;
      3'b011:  return OP_MULHU;
      3'b100:  return OP_DIV;
      3'b101:  return OP_DIVU;
      3'b110:  return OP_REM;
      default: return OP_REMU;
    endcase
  endfunction

  function automatic logic [2:0] size_onehot(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'b001;
      2'b01:   return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  logic [31:0]     inst_mem [DEPTH];
  logic [PC_W-1:0] pc_mem   [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            full, empty, push, load;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = rst_n && !flush && !full;
  assign push     = in_valid && in_ready;
  assign load     = !empty && (!out_valid || out_ready);
  assign out_count = count;

  // NOTE: the FIFO storage has no reset; count and pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= in_inst;
      pc_mem[wr_ptr]   <= in_pc;
    end
  end

  logic [31:0] head;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  assign head   = inst_mem[rd_ptr];
  assign opcode = head[6:0];
  assign funct3 = head[14:12];
  assign funct7 = head[31:25];
  assign imm_i  = {{20{head[31]}}, head[31:20]};
  assign imm_s  = {{20{head[31]}}, head[31:25], head[11:7]};
  assign imm_b  = {{19{head[31]}}, head[31], head[7], head[30:25], head[11:8], 1'b0};
  assign imm_u  = {head[31:12], 12'b0};
  assign imm_j  = {{11{head[31]}}, head[31], head[19:12], head[20], head[30:21], 1'b0};
  assign imm_sh = {27'b0, head[24:20]};

  dec_t dec;

  // NOTE: dec gets a full default before the case, so no path through this block can infer a latch.
  always_comb begin
    dec     = '0;
    dec.rs1 = head[19:15];
    dec.rs2 = head[24:20];
    dec.rd  = head[11:7];
    case (opcode)
      OPC_OP: begin
        dec.write_reg = 1'b1;
        if (funct7 == 7'b0000000)                         dec.alu_op = base_op(funct3);
        else if (funct7 == 7'b0100000 && funct3 == 3'b000) dec.alu_op = OP_SUB;
        else if (funct7 == 7'b0100000 && funct3 == 3'b101) dec.alu_op = OP_SRA;
        else if (funct7 == 7'b0000001 && ENABLE_M)          dec.alu_op = m_op(funct3);
        else                                                dec.illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.write_reg = 1'b1;
        dec.use_imm   = 1'b1;
        dec.imm       = imm_i;
        dec.alu_op    = base_op(funct3);
        // Shift-immediates reuse the funct7 slot as an encoding qualifier.
        if (funct3 == 3'b001) begin
          dec.imm = imm_sh;
          if (funct7 != 7'b0000000) dec.illegal = 1'b1;
        end else if (funct3 == 3'b101) begin
          dec.imm = imm_sh;
          if (funct7 == 7'b0100000)      dec.alu_op  = OP_SRA;
          else if (funct7 != 7'b0000000) dec.illegal = 1'b1;
        end
      end
      OPC_LOAD: begin
        dec.write_reg  = 1'b1;
        dec.use_imm    = 1'b1;
        dec.imm        = imm_i;
        dec.alu_op     = OP_ADD;
        dec.is_load    = 1'b1;
        dec.mem_len    = size_onehot(funct3[1:0]);
        dec.mem_signed = !funct3[2];
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) dec.illegal = 1'b1;
      end
      OPC_STORE: begin
        dec.use_imm = 1'b1;
        dec.imm     = imm_s;
        dec.alu_op  = OP_ADD;
        dec.rd      = '0;
        dec.mem_len = size_onehot(funct3[1:0]);
        dec.mem_wea = {funct3[1], funct3[1], funct3[1] | funct3[0], 1'b1};
        if (funct3[2] || funct3[1:0] == 2'b11) dec.illegal = 1'b1;
      end
      OPC_BRANCH: begin
        dec.imm = imm_b;
        dec.rd  = '0;
        case (funct3)
          3'b000:  dec.alu_op  = OP_BEQ;
          3'b001:  dec.alu_op  = OP_BNE;
          3'b100:  dec.alu_op  = OP_BLT;
          3'b101:  dec.alu_op  = OP_BGE;
          3'b110:  dec.alu_op  = OP_BLTU;
          3'b111:  dec.alu_op  = OP_BGEU;
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_LUI:   begin dec.write_reg = 1'b1; dec.use_imm = 1'b1; dec.imm = imm_u; dec.alu_op = OP_LUI;   end
      OPC_AUIPC: begin dec.write_reg = 1'b1; dec.use_imm = 1'b1; dec.imm = imm_u; dec.alu_op = OP_AUIPC; end
      OPC_JAL:   begin dec.write_reg = 1'b1; dec.use_imm = 1'b1; dec.imm = imm_j; dec.alu_op = OP_JAL;   end
      OPC_JALR: begin
        dec.write_reg = 1'b1;
        dec.use_imm   = 1'b1;
        dec.imm       = imm_i;
        dec.alu_op    = OP_JALR;
        if (funct3 != 3'b000) dec.illegal = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    // An illegal bundle must never cause a register write or memory side effect downstream.
    if (dec.illegal) begin
      dec.alu_op     = OP_NOP;
      dec.imm        = '0;
      dec.use_imm    = 1'b0;
      dec.write_reg  = 1'b0;
      dec.mem_wea    = '0;
      dec.mem_len    = '0;
      dec.mem_signed = 1'b0;
      dec.is_load    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (load) rd_ptr <= rd_ptr + AW'(1);
      if (push && !load)      count <= count + (AW+1)'(1);
      else if (!push && load) count <= count - (AW+1)'(1);
      if (load)           out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_pc         <= '0;
      out_alu_op     <= '0;
      out_rs1        <= '0;
      out_rs2        <= '0;
      out_rd         <= '0;
      out_imm        <= '0;
      out_use_imm    <= 1'b0;
      out_write_reg  <= 1'b0;
      out_mem_wea    <= '0;
      out_mem_len    <= '0;
      out_mem_signed <= 1'b0;
      out_is_load    <= 1'b0;
      out_illegal    <= 1'b0;
    end else if (!flush && load) begin
      out_pc         <= pc_mem[rd_ptr];
      out_alu_op     <= dec.alu_op;
      out_rs1        <= dec.rs1;
      out_rs2        <= dec.rs2;
      out_rd         <= dec.rd;
      out_imm        <= dec.imm;
      out_use_imm    <= dec.use_imm;
      out_write_reg  <= dec.write_reg;
      out_mem_wea    <= dec.mem_wea;
      out_mem_len    <= dec.mem_len;
      out_mem_signed <= dec.mem_signed;
      out_is_load    <= dec.is_load;
      out_illegal    <= dec.illegal;
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Random and directed stimulus for decode_queue (ENABLE_M=0 and ENABLE_M=1 side by side),
// checked against a queue-based flow model and a mnemonic-table decode model.
module tb_decode_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  alu_op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
    logic        write_reg;
    logic [3:0]  wea;
    logic [2:0]  len;
    logic        sgn;
    logic        is_load;
    logic        illegal;
    logic [2:0]  count;
  } obs_t;

  typedef struct packed {
    logic [4:0]  alu_op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
    logic        write_reg;
    logic [3:0]  wea;
    logic [2:0]  len;
    logic        sgn;
    logic        is_load;
    logic        illegal;
    logic        chk_rs1;
    logic        chk_rs2;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_pc;

  logic in_ready0, o0_valid, o0_use_imm, o0_write_reg, o0_sgn, o0_is_load, o0_illegal;
  logic [31:0] o0_pc, o0_imm;
  logic [4:0]  o0_alu_op, o0_rs1, o0_rs2, o0_rd;
  logic [3:0]  o0_wea;
  logic [2:0]  o0_len, o0_count;

  logic in_ready1, o1_valid, o1_use_imm, o1_write_reg, o1_sgn, o1_is_load, o1_illegal;
  logic [31:0] o1_pc, o1_imm;
  logic [4:0]  o1_alu_op, o1_rs1, o1_rs2, o1_rd;
  logic [3:0]  o1_wea;
  logic [2:0]  o1_len, o1_count;

  obs_t obs0, obs1;

  always #5 clk = ~clk;

  decode_queue #(.DEPTH(DEPTH), .ENABLE_M(1'b0), .PC_W(32)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(o0_valid), .out_ready(out_ready),
    .out_pc(o0_pc), .out_alu_op(o0_alu_op), .out_rs1(o0_rs1), .out_rs2(o0_rs2), .out_rd(o0_rd),
    .out_imm(o0_imm), .out_use_imm(o0_use_imm), .out_write_reg(o0_write_reg),
    .out_mem_wea(o0_wea), .out_mem_len(o0_len), .out_mem_signed(o0_sgn),
    .out_is_load(o0_is_load), .out_illegal(o0_illegal), .out_count(o0_count)
  );

  decode_queue #(.DEPTH(DEPTH), .ENABLE_M(1'b1), .PC_W(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(o1_valid), .out_ready(out_ready),
    .out_pc(o1_pc), .out_alu_op(o1_alu_op), .out_rs1(o1_rs1), .out_rs2(o1_rs2), .out_rd(o1_rd),
    .out_imm(o1_imm), .out_use_imm(o1_use_imm), .out_write_reg(o1_write_reg),
    .out_mem_wea(o1_wea), .out_mem_len(o1_len), .out_mem_signed(o1_sgn),
    .out_is_load(o1_is_load), .out_illegal(o1_illegal), .out_count(o1_count)
  );

  assign obs0 = {o0_valid, o0_pc, o0_alu_op, o0_rs1, o0_rs2, o0_rd, o0_imm, o0_use_imm,
                 o0_write_reg, o0_wea, o0_len, o0_sgn, o0_is_load, o0_illegal, o0_count};
  assign obs1 = {o1_valid, o1_pc, o1_alu_op, o1_rs1, o1_rs2, o1_rd, o1_imm, o1_use_imm,
                 o1_write_reg, o1_wea, o1_len, o1_sgn, o1_is_load, o1_illegal, o1_count};

  int n_checks = 0;
  int n_pass   = 0;

  // Flow model: the FIFO is a queue of {pc, inst}; the slot holds the raw instruction.
  logic [63:0] mq[$];
  bit          mvalid = 1'b0;
  bit          mzero  = 1'b1;
  logic [31:0] m_inst, m_pc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] sext(input logic [31:0] v, input int n);
    logic [31:0] sign, x;
    sign = 32'd1 << (n - 1);
    x    = v & ((sign << 1) - 32'd1);
    return (x ^ sign) - sign;
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] w, input bit m);
    exp_t       e;
    int         code;
    int         alu_tab [8];
    int         br_tab  [8];
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
    alu_tab = '{1, 3, 4, 5, 6, 7, 9, 10};
    br_tab  = '{15, 16, -1, -1, 17, 18, 19, 20};
    f3 = w[14:12];
    f7 = w[31:25];
    i_imm = sext(32'(w[31:20]), 12);
    s_imm = sext((32'(w[31:25]) << 5) | 32'(w[11:7]), 12);
    b_imm = sext((32'(w[31]) << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1), 13);
    u_imm = w & 32'hFFFF_F000;
    j_imm = sext((32'(w[31]) << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1), 21);
    e = '0;
    code = -1;
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    e.rd  = w[11:7];
    case (w[6:0])
      7'h33: begin
        e.chk_rs1 = 1'b1; e.chk_rs2 = 1'b1;
        if (f7 == 7'h00)                  code = alu_tab[f3];
        else if (f7 == 7'h20 && f3 == 0)  code = 2;
        else if (f7 == 7'h20 && f3 == 5)  code = 8;
        else if (f7 == 7'h01 && m)        code = 21 + int'(f3);
      end
      7'h13: begin
        e.chk_rs1 = 1'b1; e.use_imm = 1'b1;
        if (f3 == 1 || f3 == 5) begin
          e.imm = 32'(w[24:20]);
          if (f7 == 7'h00)                 code = alu_tab[f3];
          else if (f3 == 5 && f7 == 7'h20) code = 8;
        end else begin
          e.imm = i_imm;
          code  = alu_tab[f3];
        end
      end
      7'h03: begin
        e.chk_rs1 = 1'b1; e.use_imm = 1'b1; e.imm = i_imm;
        if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
          code = 1; e.is_load = 1'b1;
          e.len = 3'(1 << f3[1:0]);
          e.sgn = (f3 < 3'd4);
        end
      end
      7'h23: begin
        e.chk_rs1 = 1'b1; e.chk_rs2 = 1'b1; e.use_imm = 1'b1; e.imm = s_imm; e.rd = '0;
        if (f3 < 3'd3) begin
          code  = 1;
          e.len = 3'(1 << f3);
          e.wea = 4'((1 << (1 << f3)) - 1);
        end
      end
      7'h63: begin
        e.chk_rs1 = 1'b1; e.chk_rs2 = 1'b1; e.imm = b_imm; e.rd = '0;
        code = br_tab[f3];
      end
      7'h37: begin e.use_imm = 1'b1; e.imm = u_imm; code = 11; end
      7'h17: begin e.use_imm = 1'b1; e.imm = u_imm; code = 12; end
      7'h6f: begin e.use_imm = 1'b1; e.imm = j_imm; code = 13; end
      7'h67: begin
        e.chk_rs1 = 1'b1; e.use_imm = 1'b1; e.imm = i_imm;
        if (f3 == 0) code = 14;
      end
      default: ;
    endcase
    if (code < 0) begin
      e.illegal = 1'b1; e.alu_op = '0; e.write_reg = 1'b0; e.wea = '0; e.is_load = 1'b0;
    end else begin
      e.alu_op    = 5'(code);
      e.write_reg = !(w[6:0] == 7'h63 || w[6:0] == 7'h23);
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 9) == 0) return w;
    case ($urandom_range(0, 9))
      0: w[6:0] = 7'h33;  1: w[6:0] = 7'h13;  2: w[6:0] = 7'h03;  3: w[6:0] = 7'h23;
      4: w[6:0] = 7'h63;  5: w[6:0] = 7'h37;  6: w[6:0] = 7'h17;  7: w[6:0] = 7'h6f;
      8: w[6:0] = 7'h67;  default: w[6:0] = 7'h7f;
    endcase
    if (w[6:0] == 7'h33 || w[6:0] == 7'h13) begin
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        2: w[31:25] = 7'h01;
        default: ;
      endcase
    end
    return w;
  endfunction

  task automatic compare(input string p, input obs_t o, input bit m);
    exp_t e;
    check({p, "valid"}, 64'(o.valid), 64'(mvalid));
    check({p, "count"}, 64'(o.count), 64'(mq.size()));
    if (mvalid) begin
      e = ref_decode(m_inst, m);
      check({p, "pc"},      64'(o.pc),        64'(m_pc));
      check({p, "illegal"}, 64'(o.illegal),   64'(e.illegal));
      check({p, "alu_op"},  64'(o.alu_op),    64'(e.alu_op));
      check({p, "wr_reg"},  64'(o.write_reg), 64'(e.write_reg));
      check({p, "wea"},     64'(o.wea),       64'(e.wea));
      check({p, "is_load"}, 64'(o.is_load),   64'(e.is_load));
      if (!e.illegal) begin
        check({p, "rd"},      64'(o.rd),      64'(e.rd));
        check({p, "imm"},     64'(o.imm),     64'(e.imm));
        check({p, "use_imm"}, 64'(o.use_imm), 64'(e.use_imm));
        check({p, "len"},     64'(o.len),     64'(e.len));
        check({p, "signed"},  64'(o.sgn),     64'(e.sgn));
        if (e.chk_rs1) check({p, "rs1"}, 64'(o.rs1), 64'(e.rs1));
        if (e.chk_rs2) check({p, "rs2"}, 64'(o.rs2), 64'(e.rs2));
      end
    end else if (mzero) begin
      check({p, "rst_pc"},  64'(o.pc),  64'd0);
      check({p, "rst_imm"}, 64'(o.imm), 64'd0);
      check({p, "rst_fields"}, 64'({o.alu_op, o.rs1, o.rs2, o.rd, o.use_imm, o.write_reg,
                                    o.wea, o.len, o.sgn, o.is_load, o.illegal}), 64'd0);
    end
  endtask

  // One clock cycle: drive inputs, check in_ready, take the edge, advance the model, compare.
  task automatic step(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                      input bit rdy, input bit fl, input bit rn);
    bit exp_ready, do_push, do_load;
    in_valid = v; in_inst = inst; in_pc = pc; out_ready = rdy; flush = fl; rst_n = rn;
    #1;
    exp_ready = rn && !fl && (mq.size() < DEPTH);
    check("in_ready_m0", 64'(in_ready0), 64'(exp_ready));
    check("in_ready_m1", 64'(in_ready1), 64'(exp_ready));
    @(posedge clk);
    if (!rn) begin
      mq.delete(); mvalid = 1'b0; mzero = 1'b1;
    end else if (fl) begin
      mq.delete(); mvalid = 1'b0;
    end else begin
      do_push = v && exp_ready;
      do_load = (mq.size() > 0) && (!mvalid || rdy);
      if (do_load) begin
        {m_pc, m_inst} = mq.pop_front();
        mvalid = 1'b1; mzero = 1'b0;
      end else if (rdy) begin
        mvalid = 1'b0;
      end
      if (do_push) mq.push_back({pc, inst});
    end
    #1;
    compare("m0_", obs0, 1'b0);
    compare("m1_", obs1, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_inst = '0; in_pc = '0;
    step(1'b1, 32'h0050_0093, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0,         32'h0, 1'b0, 1'b0, 1'b0);
    check("reset_valid", 64'(o0_valid), 64'd0);
    check("reset_count", 64'(o0_count), 64'd0);

    // addi x1,x0,5 : two edges from push to a valid bundle
    step(1'b1, 32'h0050_0093, 32'h100, 1'b1, 1'b0, 1'b1);
    check("addi_lat_valid", 64'(o0_valid), 64'd0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    check("addi_valid",  64'(o0_valid),     64'd1);
    check("addi_alu",    64'(o0_alu_op),    64'd1);
    check("addi_rd",     64'(o0_rd),        64'd1);
    check("addi_imm",    64'(o0_imm),       64'd5);
    check("addi_useimm", 64'(o0_use_imm),   64'd1);
    check("addi_wr",     64'(o0_write_reg), 64'd1);
    check("addi_pc",     64'(o0_pc),        64'h100);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);

    // fill: five pushes with execute stalled, then drain in order
    for (int i = 0; i < 5; i++)
      step(1'b1, 32'h0000_0093 | (32'(i + 1) << 7), 32'h200 + 32'(4 * i), 1'b0, 1'b0, 1'b1);
    check("fill_count", 64'(o0_count),  64'd4);
    check("fill_ready", 64'(in_ready0), 64'd0);
    check("fill_pc",    64'(o0_pc),     64'h200);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
      check("drain_pc", 64'(o0_pc), 64'(32'h200 + 32'(4 * (i + 1))));
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    check("drain_empty", 64'(o0_valid), 64'd0);

    // blt / sw / mul
    step(1'b1, 32'hFE20_CEE3, 32'h300, 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'h0011_2223, 32'h304, 1'b1, 1'b0, 1'b1);
    check("blt_alu", 64'(o0_alu_op),    64'd17);
    check("blt_rd",  64'(o0_rd),        64'd0);
    check("blt_imm", 64'(o0_imm),       64'hFFFF_FFFC);
    check("blt_wr",  64'(o0_write_reg), 64'd0);
    step(1'b1, 32'h0220_81B3, 32'h308, 1'b1, 1'b0, 1'b1);
    check("sw_wea", 64'(o0_wea), 64'hF);
    check("sw_imm", 64'(o0_imm), 64'd4);
    check("sw_rd",  64'(o0_rd),  64'd0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    check("mul_m0_illegal", 64'(o0_illegal),   64'd1);
    check("mul_m0_alu",     64'(o0_alu_op),    64'd0);
    check("mul_m0_wr",      64'(o0_write_reg), 64'd0);
    check("mul_m1_alu",     64'(o1_alu_op),    64'd21);
    check("mul_m1_rd",      64'(o1_rd),        64'd3);
    check("mul_m1_wr",      64'(o1_write_reg), 64'd1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);

    // flush mid-stall with a simultaneous offer
    for (int i = 0; i < 4; i++)
      step(1'b1, rand_inst(), 32'h400 + 32'(4 * i), 1'b0, 1'b0, 1'b1);
    check("pre_flush_count", 64'(o0_count), 64'd3);
    step(1'b1, 32'h0050_0093, 32'h500, 1'b0, 1'b1, 1'b1);
    check("flush_valid", 64'(o0_valid), 64'd0);
    check("flush_count", 64'(o0_count), 64'd0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    check("flush_noenq", 64'(o0_count), 64'd0);

    // reset mid-stream
    step(1'b1, rand_inst(), 32'h600, 1'b0, 1'b0, 1'b1);
    step(1'b1, rand_inst(), 32'h604, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h0050_0093, 32'h700, 1'b1, 1'b0, 1'b0);
    check("rst_ready_low", 64'(in_ready0), 64'd0);
    check("rst_mid_valid", 64'(o0_valid),  64'd0);
    check("rst_mid_count", 64'(o0_count),  64'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    check("rst_ready_high", 64'(in_ready0), 64'd1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    check("rst_no_ghost", 64'(o0_valid), 64'd0);

    // randomized traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, rand_inst(), $urandom, $urandom_range(0, 3) != 0,
           $urandom_range(0, 63) == 0, $urandom_range(0, 199) != 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised successor to the combinational RV32I decoder: a buffered, handshaked decode stage between fetch and execute.
- Fetch pushes {inst, pc} into a DEPTH-entry FIFO.
- The FIFO head is decoded and captured in a registered output slot with valid/ready flow control.
- Adds flush, illegal-instruction detection, fully formed immediates and optional RV32M decode.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2
- ENABLE_M, 0, 1 = decode RV32M (OP 0110011, funct7 0000001); 0 = those encodings are illegal
- PC_W, 32, program-counter width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- flush  in  1  discard all queued and output-slot instructions
- in_valid  in  1  fetch offers instruction
- in_ready  out  1  queue can accept (= !full && !flush && rst_n)
- in_inst  in  32  instruction word
- in_pc  in  PC_W  instruction address
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts bundle
- out_pc  out  PC_W  pc of bundle
- out_alu_op  out  5  operation code (see Behaviour)
- out_rs1 / out_rs2 / out_rd  out  5 each  register indices
- out_imm  out  32  sign-extended immediate for the instruction's format
- out_use_imm  out  1  operand B is immediate
- out_write_reg  out  1  writes rd
- out_mem_wea  out  4  store byte enables
- out_mem_len  out  3  one-hot {word, half, byte}
- out_mem_signed  out  1  signed load
- out_is_load  out  1  load
- out_illegal  out  1  unrecognised encoding
- out_count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst_n=0 at edge): FIFO pointers and count cleared; every out_* register cleared to 0. in_ready is 0 while rst_n is low and 1 in the first cycle after release.
- Push: in_valid && in_ready at the edge writes the tail. No push when full, even if a pop happens the same cycle.
- Output slot:
  - Loads the decoded FIFO head when the FIFO is non-empty and (!out_valid || out_ready).
  - Pop and load happen at the same edge.
  - Otherwise the slot holds; all out_* stay stable while out_valid && !out_ready.
- Latency: an instruction accepted at edge N gives out_valid=1 after edge N+1. Sustained throughput is 1 instruction/cycle.
- out_valid drops after an edge where out_ready=1 and the FIFO was empty.
- Flush has priority over push, pop and load. At a flush edge, count becomes 0 and out_valid becomes 0; in_valid is ignored that cycle. Other out_* fields may hold stale values.
- Pointers wrap modulo DEPTH. Simultaneous push and pop leave count unchanged.
- out_alu_op codes:
  - NOP 0, ADD 1, SUB 2, SLL 3, SLT 4, SLTU 5, XOR 6, SRL 7, SRA 8, OR 9, AND 10
  - LUI 11, AUIPC 12, JAL 13, JALR 14
  - BEQ 15, BNE 16, BLT 17, BGE 18, BLTU 19, BGEU 20
  - MUL 21, MULH 22, MULHSU 23, MULHU 24, DIV 25, DIVU 26, REM 27, REMU 28
  - Loads and stores use ADD; I-type ALU instructions map to their R-type code.
- Immediates:
  - I: inst[31:20] sign-extended.
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - Shift-immediates: {27'b0, inst[24:20]}. SLLI/SRLI require funct7=0000000 and SRAI requires 0100000; anything else is illegal.
  - R-type: out_imm=0.
- out_rd is forced to 0 for branches and stores. out_write_reg=1 only for R, I-ALU, load, LUI, AUIPC, JAL, JALR, and M ops when ENABLE_M=1.
- out_mem_wea: SW 1111, SH 0011, SB 0001, otherwise 0000. out_mem_signed=1 for LB/LH/LW.
- Illegal encodings get out_illegal=1, out_alu_op=NOP, out_write_reg=0, out_mem_wea=0, out_is_load=0.
  - Includes unknown opcodes, unused funct3, wrong funct7, and M ops when ENABLE_M=0.
  - Opcode 1111111 is illegal.
- Reset or flush mid-stall discards the stalled bundle; no partial state survives.

Test Plan:
- Push 0x00500093 (addi x1,x0,5) at pc 0x100 with out_ready=1 → after 2 edges: out_valid=1, out_alu_op=1, out_rd=1, out_imm=5, out_use_imm=1, out_write_reg=1, out_pc=0x100.
- Push 5 back-to-back instructions with DEPTH=4 and out_ready=0 → FIFO fills (4 entries; the first is moved to the output slot) until in_ready=0 with out_count=4. Release out_ready → bundles emerge in order, one per cycle, with no loss or duplication.
- Push 0xFE20CEE3 (blt x1,x2,-4) → out_alu_op=17, out_rd=0, out_imm=0xFFFFFFFC, out_write_reg=0. Push 0x00112223 (sw x1,4(x2)) → out_mem_wea=1111, out_imm=4, out_rd=0.
- Push 0x022081B3 (mul x3,x1,x2): ENABLE_M=0 → out_illegal=1, out_alu_op=0, out_write_reg=0; ENABLE_M=1 → out_alu_op=21, out_rd=3, out_write_reg=1.
- Fill 3 entries with out_valid held and out_ready=0, then pulse flush together with in_valid=1 → next cycle out_valid=0, out_count=0, and the flush-cycle instruction is not enqueued.
- Drive rst_n=0 for 1 cycle mid-stream with in_valid=1 → all outputs 0 and out_count=0; in_ready=0 during reset and 1 the following cycle; no instruction from the reset cycle appears.
